rectangle_sbox_layer_3sh: RTL
=============================

RECTANGLE_SBOX_LAYER_3SH -- requirements
Module: rectangle_sbox_layer_3sh

Interface
REQ-001 The block SHALL have one parameter: G_PASSES, default 2, the number of second-order G-stage passes applied to every nibble (legal range 1..4).
REQ-002 clk  in  1  Single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  in  1  Asynchronous, active-low reset.
REQ-004 start  in  1  Single-cycle request to process the values on in_share1..3.
REQ-005 in_share1, in_share2, in_share3  in  64 each  3-share masked RECTANGLE state; nibble k is bits [4k+3:4k].
REQ-006 busy  out  1  High while a layer is in progress.
REQ-007 done  out  1  One-cycle pulse when the layer result is complete.
REQ-008 out_valid  out  1  High from done until the next accepted start.
REQ-009 out_share1, out_share2, out_share3  out  64 each  3-share result state.

Function
REQ-010 The block SHALL instantiate exactly one 3-share, no-fresh-randomness G-stage: 4-bit shares in, 4-bit shares out, one register of latency, no reset.
REQ-011 FSM states SHALL be IDLE, RUN and DRAIN; reset enters IDLE.
REQ-012 In IDLE with start=1, the block SHALL load in_share1..3 into the internal 3x64 buffer, clear the issue counter, assert busy, clear out_valid and enter RUN.
REQ-013 start SHALL be ignored while busy=1.
REQ-014 In RUN, on each cycle the block SHALL issue buffer nibble (cnt mod 16), all three shares, to the G-stage, where cnt is a 6-bit issue counter counting 0..16*G_PASSES-1.
REQ-015 A one-bit write-enable pipeline flag and a 4-bit write index SHALL track each issue, delayed by one cycle; when the flag is 1, the G-stage outputs SHALL overwrite that nibble in all three shares.
REQ-016 The G-stage output SHALL never be written unless the flag is set; the garbage output from the first cycle after reset SHALL therefore be discarded.
REQ-017 Back-to-back passes SHALL issue without a bubble. Nibble k of pass p+1 is issued 15 cycles after the write of pass p, so no forwarding is required.
REQ-018 When the last issue occurs (cnt = 16*G_PASSES-1), the FSM SHALL go to DRAIN. In DRAIN, after the final write-back, it SHALL pulse done, deassert busy, set out_valid and return to IDLE.
REQ-019 Latency SHALL be exactly 16*G_PASSES+1 cycles: done is high on the 16*G_PASSES+1-th rising edge after the edge that accepted start (33 for the default).
REQ-020 The three shares SHALL never be XOR-combined anywhere in the block. Share i of a nibble SHALL only meet share j inside the G-stage.
REQ-021 out_share1..3 SHALL expose the buffer, subject to REQ-027/REQ-028; the buffer SHALL hold its value in IDLE.
REQ-022 start in the same cycle as done (busy already low) SHALL be accepted on the following IDLE cycle only, not in the done cycle itself.

Reset
REQ-023 rst_n=0 SHALL asynchronously clear the FSM to IDLE, the counter, the write flag, the write index and the buffer.
REQ-024 During reset, busy=0, done=0, out_valid=0 and out_share1..3=0.
REQ-025 A reset asserted mid-operation SHALL abort the layer with no done pulse. The first start after reset release SHALL behave as from power-up.
REQ-026 The G-stage registers are not reset; REQ-016 alone SHALL guarantee correctness.

Configuration
REQ-027 With macro RECT_SBOX_OUT_GATE_EN defined, out_share1..3 SHALL be forced to 0 whenever out_valid=0, so intermediate pass values are never exposed.
REQ-028 Without RECT_SBOX_OUT_GATE_EN, out_share1..3 SHALL follow the buffer continuously, including intermediate values while busy; all timing SHALL be identical in both builds.

Verification
REQ-029 Reset, then start with in_share1=0x0123456789ABCDEF and in_share2=in_share3=0 (G_PASSES=2) -> busy for 33 cycles, done pulses once at cycle 33, and share1^share2^share3 equals the golden model (G applied twice per nibble).
REQ-030 Same unmasked value, with in_share2=in_share3=0xA5A5A5A5A5A5A5A5 -> individual shares differ from REQ-029, and the XOR of the outputs is identical to REQ-029.
REQ-031 start pulsed at cycles 5 and 20 of a run -> both ignored, a single done at cycle 33, result unchanged.
REQ-032 rst_n dropped at cycle 10 of a run, released, then a new start -> no done for the aborted run, all outputs 0 during reset, second run correct at cycle 33.
REQ-033 G_PASSES=1 and G_PASSES=4, random 3-share inputs -> done at cycles 17 and 65 respectively, and the XOR of outputs matches the golden model.
REQ-034 Build with RECT_SBOX_OUT_GATE_EN -> out_share1..3 read 0x0 on every busy cycle and equal the buffer once out_valid=1.

Source files
------------

// File: rtl/rectangle_sbox_layer_3sh.sv
// rectangle_sbox_layer_3sh: 3-share masked nibble-serial S-box layer for
// RECTANGLE. A single threshold-implemented G-stage is shared across the
// 16 nibbles and G_PASSES passes.
//
// G (unmasked), x/y bit 0 = LSB of the nibble:
//   y0 = x0 ^ x1&x2   y1 = x1 ^ x2&x3   y2 = x2 ^ x3&x0   y3 = x3
//
// Optional build macro RECT_SBOX_OUT_GATE_EN: out_share1..3 read zero
// unless out_valid is high, so intermediate pass values are never exposed.

// 3-share G-stage using direct sharing. Output share i only sees input
// shares i+1 and i+2, so no single output share ever depends on all
// three input shares. Needs no fresh randomness. One register of latency
// and no reset; the owner discards output it did not request.
module rect_g_stage_3sh (
  input  logic       clk,
  input  logic [3:0] a1,
  input  logic [3:0] a2,
  input  logic [3:0] a3,
  output logic [3:0] b1,
  output logic [3:0] b2,
  output logic [3:0] b3
);
  // One output share of G, built from two input shares j and k.
  // The linear part comes from share j. Each AND term contributes
  // jj ^ jk ^ kj.
  function automatic logic [3:0] g_share(input logic [3:0] xj, input logic [3:0] xk);
    logic [3:0] y;
    y[0] = xj[0] ^ (xj[1] & xj[2]) ^ (xj[1] & xk[2]) ^ (xk[1] & xj[2]);
    y[1] = xj[1] ^ (xj[2] & xj[3]) ^ (xj[2] & xk[3]) ^ (xk[2] & xj[3]);
    y[2] = xj[2] ^ (xj[3] & xj[0]) ^ (xj[3] & xk[0]) ^ (xk[3] & xj[0]);
    y[3] = xj[3];
    return y;
  endfunction

  logic [3:0] b1_d, b2_d, b3_d;

  // Non-complete share functions.
  always_comb begin
    b1_d = g_share(a2, a3);
    b2_d = g_share(a3, a1);
    b3_d = g_share(a1, a2);
  end

  // Output register, deliberately not reset.
  always_ff @(posedge clk) begin
    b1 <= b1_d;
    b2 <= b2_d;
    b3 <= b3_d;
  end
endmodule

module rectangle_sbox_layer_3sh #(
  parameter int G_PASSES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [63:0] in_share1,
  input  logic [63:0] in_share2,
  input  logic [63:0] in_share3,
  output logic        busy,
  output logic        done,
  output logic        out_valid,
  output logic [63:0] out_share1,
  output logic [63:0] out_share2,
  output logic [63:0] out_share3
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [5:0] LAST = 6'(16 * G_PASSES - 1);

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [3:0]  widx_q, widx_d;
  logic [63:0] buf1_q, buf1_d, buf2_q, buf2_d, buf3_q, buf3_d;
  logic        done_q, done_d;
  logic        out_valid_q, out_valid_d;

  logic [5:0]  rd_base, wr_base;
  logic [3:0]  g1_in, g2_in, g3_in, g1_out, g2_out, g3_out;

  assign rd_base = {cnt_q[3:0], 2'b00};
  assign wr_base = {widx_q, 2'b00};
  assign g1_in   = buf1_q[rd_base +: 4];
  assign g2_in   = buf2_q[rd_base +: 4];
  assign g3_in   = buf3_q[rd_base +: 4];

  rect_g_stage_3sh u_g (
    .clk (clk),
    .a1  (g1_in),
    .a2  (g2_in),
    .a3  (g3_in),
    .b1  (g1_out),
    .b2  (g2_out),
    .b3  (g3_out)
  );

  // Next-state, issue sequencing and write-back of the G-stage result.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = 1'b0;
    widx_d      = widx_q;
    buf1_d      = buf1_q;
    buf2_d      = buf2_q;
    buf3_d      = buf3_q;
    done_d      = 1'b0;
    out_valid_d = out_valid_q;

    // Only a flagged issue may land; G-stage garbage is otherwise ignored.
    if (we_q) begin
      buf1_d[wr_base +: 4] = g1_out;
      buf2_d[wr_base +: 4] = g2_out;
      buf3_d[wr_base +: 4] = g3_out;
    end

    case (state_q)
      IDLE: begin
        // A start in the done cycle is not taken; it must persist a cycle.
        if (start && !done_q) begin
          buf1_d      = in_share1;
          buf2_d      = in_share2;
          buf3_d      = in_share3;
          cnt_d       = '0;
          out_valid_d = 1'b0;
          state_d     = RUN;
        end
      end
      RUN: begin
        we_d   = 1'b1;
        widx_d = cnt_q[3:0];
        if (cnt_q == LAST) state_d = DRAIN;
        else               cnt_d   = cnt_q + 6'd1;
      end
      DRAIN: begin
        // The final write-back lands on this edge.
        done_d      = 1'b1;
        out_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      widx_q      <= '0;
      buf1_q      <= '0;
      buf2_q      <= '0;
      buf3_q      <= '0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      widx_q      <= widx_d;
      buf1_q      <= buf1_d;
      buf2_q      <= buf2_d;
      buf3_q      <= buf3_d;
      done_q      <= done_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign out_valid = out_valid_q;

`ifdef RECT_SBOX_OUT_GATE_EN
  assign out_share1 = out_valid_q ? buf1_q : 64'h0;
  assign out_share2 = out_valid_q ? buf2_q : 64'h0;
  assign out_share3 = out_valid_q ? buf3_q : 64'h0;
`else
  assign out_share1 = buf1_q;
  assign out_share2 = buf2_q;
  assign out_share3 = buf3_q;
`endif
endmodule
